// File: rtl/add32_arbiter.sv
// Two-requester round-robin front end sharing a single 32-bit adder.
// Each operation walks IDLE -> CALC -> RESP; results stay registered until the next CALC.

module add32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  input  logic        add,
  output logic [31:0] s,
  output logic        cout
);

  logic [32:0] full;

  always_comb begin
    full = '0;
    if (add) begin
      full = {1'b0, a} + {1'b0, b} + {32'b0, cin};
    end
  end

  assign s    = full[31:0];
  assign cout = full[32];

endmodule

module add32_arbiter (
  input  logic        m_clock,
  input  logic        p_reset,
  input  logic        req0,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  input  logic        cin0,
  input  logic        req1,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  input  logic        cin1,
  output logic        done0,
  output logic        done1,
  output logic [31:0] sum,
  output logic        cout,
  output logic        ov,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t             state_q, state_d;
  logic signed [31:0] opa_q, opa_d;
  logic signed [31:0] opb_q, opb_d;
  logic               cin_q, cin_d;
  logic               gnt_q, gnt_d;
  logic               last_q, last_d;
  logic        [31:0] sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ov_q, ov_d;

  logic               add_en;
  logic               gsel;
  logic        [31:0] add_s;
  logic               add_c;

  // Signed overflow: operands agree in sign but the result does not.
  function automatic logic signed_ov(input logic a31, input logic b31, input logic s31);
    return (~a31 & ~b31 & s31) | (a31 & b31 & ~s31);
  endfunction

  add32 u_add32 (
    .a    (opa_q),
    .b    (opb_q),
    .cin  (cin_q),
    .add  (add_en),
    .s    (add_s),
    .cout (add_c)
  );

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    cin_d   = cin_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ov_d    = ov_q;
    add_en  = 1'b0;
    // On a tie the requester not served last wins; otherwise the sole requester.
    gsel    = (req0 & req1) ? ~last_q : req1;

    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          opa_d   = gsel ? a1   : a0;
          opb_d   = gsel ? b1   : b0;
          cin_d   = gsel ? cin1 : cin0;
          gnt_d   = gsel;
          last_d  = gsel;
          state_d = CALC;
        end
      end
      CALC: begin
        add_en  = 1'b1;
        sum_d   = add_s;
        cout_d  = add_c;
        ov_d    = signed_ov(opa_q[31], opb_q[31], add_s[31]);
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge m_clock) begin
    if (p_reset) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      cin_q   <= 1'b0;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      cin_q   <= cin_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ov_q    <= ov_d;
    end
  end

  assign done0 = (state_q == RESP) & ~gnt_q;
  assign done1 = (state_q == RESP) &  gnt_q;
  assign busy  = (state_q != IDLE);
  assign sum   = sum_q;
  assign cout  = cout_q;
  assign ov    = ov_q;

endmodule

// File: tb/tb_add32_arbiter.sv
// Scoreboard bench for add32_arbiter: expected results queued at request time,
// popped and compared (including arrival cycle) when a done pulse appears.

module tb_add32_arbiter;

  logic        clk;
  logic        p_reset;
  logic        req0, req1;
  logic [31:0] a0, b0, a1, b1;
  logic        cin0, cin1;
  logic        done0, done1;
  logic [31:0] sum;
  logic        cout, ov, busy;

  typedef struct {
    logic        id;
    logic [31:0] s;
    logic        c;
    logic        o;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          cyc;
  int          nchecks;
  int          nerrors;
  logic [31:0] last_s;

  add32_arbiter dut (
    .m_clock (clk),
    .p_reset (p_reset),
    .req0    (req0),
    .a0      (a0),
    .b0      (b0),
    .cin0    (cin0),
    .req1    (req1),
    .a1      (a1),
    .b1      (b1),
    .cin1    (cin1),
    .done0   (done0),
    .done1   (done1),
    .sum     (sum),
    .cout    (cout),
    .ov      (ov),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchecks++;
    if (obs !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Result monitor
  always @(negedge clk) begin
    if (done0 | done1) begin
      chk("done_onehot", 64'(done0 & done1), 64'd0);
      if (sb.size() == 0) begin
        chk("unexp_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("id",   64'(done1), 64'(e.id));
        chk("sum",  64'(sum),   64'(e.s));
        chk("cout", 64'(cout),  64'(e.c));
        chk("ov",   64'(ov),    64'(e.o));
        chk("lat",  64'(cyc),   64'(e.cyc));
        last_s = e.s;
      end
    end
  end

  task automatic wait_empty();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      chk("timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  task automatic do_op(input logic id, input logic [31:0] a, input logic [31:0] b,
                       input logic ci, input logic [31:0] es, input logic ec,
                       input logic eo, input bit scramble);
    @(posedge clk); #1;
    if (id == 1'b0) begin
      req0 = 1'b1; a0 = a; b0 = b; cin0 = ci;
    end else begin
      req1 = 1'b1; a1 = a; b1 = b; cin1 = ci;
    end
    sb.push_back('{id: id, s: es, c: ec, o: eo, cyc: cyc + 2});
    @(posedge clk); #1;
    chk("busy_calc", 64'(busy), 64'd1);
    if (scramble) begin
      if (id == 1'b0) begin
        a0 = ~a; b0 = ~b; cin0 = ~ci;
      end else begin
        a1 = ~a; b1 = ~b; cin1 = ~ci;
      end
    end
    wait_empty();
    @(posedge clk); #1;
    if (id == 1'b0) req0 = 1'b0;
    else            req1 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [32:0] full;
    logic [31:0] ra, rb;
    logic        rc, rid, rov;
    int          n;

    nchecks = 0;
    nerrors = 0;
    cyc     = 0;
    last_s  = '0;
    p_reset = 1'b1;
    req0 = 1'b1; req1 = 1'b0;
    a0 = 32'hDEAD_BEEF; b0 = 32'h1; cin0 = 1'b0;
    a1 = '0; b1 = '0; cin1 = 1'b0;

    // Reset with a request present: must be ignored
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",  64'(busy),  64'd0);
    chk("rst_done0", 64'(done0), 64'd0);
    chk("rst_done1", 64'(done1), 64'd0);
    chk("rst_sum",   64'(sum),   64'd0);
    chk("rst_cout",  64'(cout),  64'd0);
    chk("rst_ov",    64'(ov),    64'd0);
    @(posedge clk); #1;
    p_reset = 1'b0;
    req0    = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", 64'(busy), 64'd0);

    // Directed vectors
    do_op(1'b0, 32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0, 1'b0, 1'b0);
    do_op(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    do_op(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    do_op(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
    do_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);

    // Operands changed during CALC must not affect the result
    do_op(1'b0, 32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_678A, 1'b0, 1'b0, 1'b1);

    // Result holds while idle
    repeat (4) @(negedge clk);
    chk("hold_sum", 64'(sum), 64'(last_s));

    // Reset fresh, then both requesters held together: strict alternation, 0 first
    @(posedge clk); #1;
    p_reset = 1'b1;
    @(posedge clk); #1;
    p_reset = 1'b0;
    a0 = 32'd5;  b0 = 32'd6;  cin0 = 1'b0;
    a1 = 32'h10; b1 = 32'h20; cin1 = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    sb.push_back('{id: 1'b0, s: 32'h0000_000B, c: 1'b0, o: 1'b0, cyc: cyc + 2});
    sb.push_back('{id: 1'b1, s: 32'h0000_0031, c: 1'b0, o: 1'b0, cyc: cyc + 5});
    sb.push_back('{id: 1'b0, s: 32'h0000_000B, c: 1'b0, o: 1'b0, cyc: cyc + 8});
    sb.push_back('{id: 1'b1, s: 32'h0000_0031, c: 1'b0, o: 1'b0, cyc: cyc + 11});
    wait_empty();
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;

    // Reset during CALC aborts the op
    @(posedge clk); #1;
    req0 = 1'b1; a0 = 32'h0000_0100; b0 = 32'h0000_0200; cin0 = 1'b0;
    @(posedge clk); #1;
    chk("abort_in_calc", 64'(busy), 64'd1);
    p_reset = 1'b1;
    req0    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy", 64'(busy),  64'd0);
    chk("abort_sum",  64'(sum),   64'd0);
    chk("abort_done", 64'(done0), 64'd0);
    @(posedge clk); #1;
    p_reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_nodone", 64'(done0 | done1), 64'd0);
    do_op(1'b0, 32'h0000_0100, 32'h0000_0200, 1'b0, 32'h0000_0300, 1'b0, 1'b0, 1'b0);

    // Random operations against an arithmetic reference
    for (int i = 0; i < 8; i++) begin
      ra   = $urandom;
      rb   = $urandom;
      rc   = 1'($urandom_range(0, 1));
      rid  = 1'(i % 2);
      full = {1'b0, ra} + {1'b0, rb} + {32'b0, rc};
      rov  = (ra[31] == rb[31]) && (full[31] != ra[31]);
      do_op(rid, ra, rb, rc, full[31:0], full[32], rov, (i % 3) == 0);
    end

    n = 0;
    while (sb.size() != 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", nchecks, nerrors);
    $finish;
  end

endmodule
